// File: rtl/fix_mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth fixed-point multiplier.
package fix_mult_pkg;

    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_e;

    function automatic int unsigned booth_iter(input int unsigned width);
        return (width + 2) / 2;
    endfunction

    // Saturation bound for an out-of-range value, chosen by its sign and the mode.
    function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W-1:0] value,
                                                   input int unsigned width,
                                                   input logic is_signed);
        logic [MAX_W-1:0] ones;
        ones = {MAX_W{1'b1}} >> (MAX_W - width);
        if (!is_signed) return ones;
        if (value[MAX_W-1]) return ~(ones >> 1) & ones;
        return ones >> 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit decoder: 3-bit multiplier window -> digit and signed partial product.
module booth_r4_enc
    import fix_mult_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 16
) (
    input  logic [2:0]             window_i,
    input  logic [INPUT_WIDTH+1:0] multiplicand_i,
    output booth_digit_e           digit_o,
    output logic [INPUT_WIDTH+2:0] partial_o
);

    localparam int unsigned PPW = INPUT_WIDTH + 3;

    logic [PPW-1:0] a1;
    logic [PPW-1:0] a2;

    assign a1 = {multiplicand_i[INPUT_WIDTH+1], multiplicand_i};
    assign a2 = {multiplicand_i, 1'b0};

    always_comb begin
        digit_o = ZERO;
        unique case (window_i)
            3'b000, 3'b111: digit_o = ZERO;
            3'b001, 3'b010: digit_o = P1;
            3'b011:         digit_o = P2;
            3'b100:         digit_o = M2;
            3'b101, 3'b110: digit_o = M1;
            default:        digit_o = ZERO;
        endcase
    end

    always_comb begin
        partial_o = '0;
        case (digit_o)
            P1:      partial_o = a1;
            P2:      partial_o = a2;
            M1:      partial_o = -a1;
            M2:      partial_o = -a2;
            default: partial_o = '0;
        endcase
    end

endmodule

// File: rtl/fix_mult_booth_seq.sv
// Iterative radix-4 Booth multiplier with scaling, rounding and saturation; one op in flight.
module fix_mult_booth_seq
    import fix_mult_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned OUTPUT_WIDTH = 32,
    parameter int unsigned FRAC_BITS    = 0,
    parameter bit          ROUND_EN     = 1'b1,
    parameter bit          SAT_EN       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  multiplicand,
    input  logic [INPUT_WIDTH-1:0]  multiplier,
    input  logic                    signed_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned W      = INPUT_WIDTH;
    localparam int unsigned EW     = W + 2;
    localparam int unsigned AW     = 2 * W + 4;
    localparam int unsigned PW     = 2 * W + 2;
    localparam int unsigned ITER   = booth_iter(W);
    localparam int unsigned CNT_W  = $clog2(ITER);
    localparam int unsigned RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic [PW-1:0] RND_ADD =
        (ROUND_EN && FRAC_BITS > 0) ? (PW'(1) << RND_SH) : '0;

    state_e                  state_q, state_d;
    logic [EW-1:0]           a_q, a_d, b_q, b_d;
    logic                    mode_q, mode_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;

    logic [EW:0]             b_pad;
    logic [2:0]              window;
    booth_digit_e            digit;
    logic [EW:0]             pp;
    logic [AW-1:0]           pp_ext;
    logic [AW-1:0]           acc_next;
    logic [PW-1:0]           rounded;
    logic [PW-1:0]           scaled;
    logic                    fits;
    logic [OUTPUT_WIDTH-1:0] clamp;
    logic [OUTPUT_WIDTH-1:0] final_res;

    // Window {b[2i+1], b[2i], b[2i-1]} with b[-1] supplied by the padded zero.
    assign b_pad  = {b_q, 1'b0};
    assign window = 3'(b_pad >> {cnt_q, 1'b0});

    booth_r4_enc #(
        .INPUT_WIDTH(W)
    ) u_enc (
        .window_i      (window),
        .multiplicand_i(a_q),
        .digit_o       (digit),
        .partial_o     (pp)
    );

    assign pp_ext   = {{(W + 1){pp[EW]}}, pp};
    assign acc_next = acc_q + ((digit == ZERO) ? '0 : (pp_ext << {cnt_q, 1'b0}));

    // Extended operands keep the product sign-correct in both modes, so one arithmetic
    // shift serves signed and unsigned alike.
    assign rounded = acc_next[PW-1:0] + RND_ADD;
    assign scaled  = $signed(rounded) >>> FRAC_BITS;

    assign fits = mode_q ? ((&scaled[PW-1:OUTPUT_WIDTH-1]) | ~(|scaled[PW-1:OUTPUT_WIDTH-1]))
                         : ~(|scaled[PW-1:OUTPUT_WIDTH]);

    assign clamp     = OUTPUT_WIDTH'(sat_clamp({{(MAX_W - PW){scaled[PW-1]}}, scaled},
                                               OUTPUT_WIDTH, mode_q));
    assign final_res = (!fits && SAT_EN) ? clamp : scaled[OUTPUT_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = {{2{multiplicand[W-1] & signed_mode}}, multiplicand};
                    b_d     = {{2{multiplier[W-1] & signed_mode}}, multiplier};
                    mode_d  = signed_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    result_d = final_res;
                    ovf_d    = ~fits;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fix_mult_booth_seq.sv
// Directed and random checks of the Booth multiplier across four scaling configurations.
module tb_fix_mult_booth_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;

    wire  [3:0]  in_rdy;
    wire  [3:0]  o_vld;
    wire  [3:0]  ovf;
    wire  [3:0]  bsy;
    logic [31:0] r0;
    logic [15:0] r1, r2, r3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // d0: 32-bit integer product; d1..d3: Q1.15 with round/sat variants.
    fix_mult_booth_seq u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .multiplicand(a), .multiplier(b), .signed_mode(signed_mode),
        .out_valid(o_vld[0]), .out_ready(out_ready), .result(r0), .overflow(ovf[0]),
        .busy(bsy[0])
    );
    fix_mult_booth_seq #(
        .OUTPUT_WIDTH(16), .FRAC_BITS(15), .ROUND_EN(1'b1), .SAT_EN(1'b1)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .multiplicand(a), .multiplier(b), .signed_mode(signed_mode),
        .out_valid(o_vld[1]), .out_ready(out_ready), .result(r1), .overflow(ovf[1]),
        .busy(bsy[1])
    );
    fix_mult_booth_seq #(
        .OUTPUT_WIDTH(16), .FRAC_BITS(15), .ROUND_EN(1'b1), .SAT_EN(1'b0)
    ) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .multiplicand(a), .multiplier(b), .signed_mode(signed_mode),
        .out_valid(o_vld[2]), .out_ready(out_ready), .result(r2), .overflow(ovf[2]),
        .busy(bsy[2])
    );
    fix_mult_booth_seq #(
        .OUTPUT_WIDTH(16), .FRAC_BITS(15), .ROUND_EN(1'b0), .SAT_EN(1'b1)
    ) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[3]),
        .multiplicand(a), .multiplier(b), .signed_mode(signed_mode),
        .out_valid(o_vld[3]), .out_ready(out_ready), .result(r3), .overflow(ovf[3]),
        .busy(bsy[3])
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
        logic [3:0]  ovf;  // {d0, d1, d2, d3}
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (o_vld[0] !== 1'b1 && lat < 40);
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [3:0] eo);
        check({tag, " valid"}, 64'(o_vld), 64'hF);
        check({tag, " d0"}, {ovf[0], r0}, {eo[3], e0});
        check({tag, " d1"}, {ovf[1], r1}, {eo[2], e1});
        check({tag, " d2"}, {ovf[2], r2}, {eo[1], e2});
        check({tag, " d3"}, {ovf[3], r3}, {eo[0], e3});
    endtask

    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vs, input logic [31:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [3:0] eo);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_rdy), 64'hF);
        a = va;
        b = vb;
        signed_mode = vs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        check({tag, " latency"}, 64'(lat), 64'd9);
        check_outs(tag, e0, e1, e2, e3, eo);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Independent integer reference for one configuration.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic sm,
                                  input int o, input int f, input bit rnd, input bit sat,
                                  output logic [31:0] r, output logic ov);
        longint p, v, mn, mx;
        if (sm) p = longint'($signed(ma)) * longint'($signed(mb));
        else    p = longint'(ma) * longint'(mb);
        if (rnd && f > 0) p = p + (longint'(1) << (f - 1));
        v = p >>> f;
        if (sm) begin
            mn = -(longint'(1) << (o - 1));
            mx = (longint'(1) << (o - 1)) - 1;
        end else begin
            mn = 0;
            mx = (longint'(1) << o) - 1;
        end
        ov = (v < mn) || (v > mx);
        if (ov && sat) v = (v < mn) ? mn : mx;
        r = 32'(v & ((longint'(1) << o) - 1));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] e0, e1, e2, e3;
        logic        o0, o1, o2, o3;

        //            a         b         sm    d0             d1        d2        d3        ovf
        tbl[0]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 16'h7FFF, 16'h8000, 16'h7FFF, 4'b0111};
        tbl[1]  = '{16'hFFFF, 16'h0003, 1'b1, 32'hFFFF_FFFD, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000};
        tbl[2]  = '{16'hFFFF, 16'h0003, 1'b0, 32'h0002_FFFD, 16'h0006, 16'h0006, 16'h0005, 4'b0000};
        tbl[3]  = '{16'h4000, 16'h4000, 1'b1, 32'h1000_0000, 16'h2000, 16'h2000, 16'h2000, 4'b0000};
        tbl[4]  = '{16'h0001, 16'h4000, 1'b1, 32'h0000_4000, 16'h0001, 16'h0001, 16'h0000, 4'b0000};
        tbl[5]  = '{16'h0007, 16'h0006, 1'b1, 32'h0000_002A, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
        tbl[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 16'hFFFF, 16'hFFFC, 16'hFFFF, 4'b0111};
        tbl[7]  = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 16'h8001, 16'h8001, 16'h8001, 4'b0000};
        tbl[8]  = '{16'h0000, 16'h1234, 1'b1, 32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
        tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
        tbl[10] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0000};
        tbl[11] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000};
        tbl[12] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 16'h8000, 16'h8000, 16'h8000, 4'b0000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset flags", {in_rdy, o_vld, bsy, ovf}, {4'hF, 4'h0, 4'h0, 4'h0});
        check("reset result", {r0, r1, r2, r3}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm,
                    tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].ovf);

        // Backpressure: result held, new request ignored until the DONE->IDLE edge.
        @(negedge clk);
        a = 16'h0003;
        b = 16'hFFFB;
        signed_mode = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0007;
        b = 16'h0006;
        wait_out(lat);
        check("bp latency", 64'(lat), 64'd9);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d", k), {o_vld[0], in_rdy[0], ovf[0], r0},
                  {1'b1, 1'b0, 1'b0, 32'hFFFF_FFF1});
        end
        out_ready = 1'b1;
        #1 check("bp release in_ready", 64'(in_rdy[0]), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp idle", {bsy[0], in_rdy[0], o_vld[0]}, 3'b010);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp re-accept", {bsy[0], in_rdy[0]}, 2'b10);
        wait_out(lat);
        check("bp2 latency", 64'(lat), 64'd9);
        check_outs("bp2", 32'h0000_002A, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of CALC aborts with no output.
        @(negedge clk);
        a = 16'h4000;
        b = 16'h4000;
        signed_mode = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre-abort busy", {o_vld[0], bsy[0]}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("abort flags", {in_rdy, o_vld, bsy, ovf}, {4'hF, 4'h0, 4'h0, 4'h0});
        check("abort result", 64'(r0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (o_vld != 4'h0) seen = 1;
        end
        check("no output after abort", 64'(seen), 64'd0);
        run_vec("post-abort 7*6", 16'h0007, 16'h0006, 1'b1,
                32'h0000_002A, 16'h0000, 16'h0000, 16'h0000, 4'b0000);

        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, 32, 0, 1'b1, 1'b1, e0, o0);
            model(ra, rb, rs, 16, 15, 1'b1, 1'b1, e1, o1);
            model(ra, rb, rs, 16, 15, 1'b1, 1'b0, e2, o2);
            model(ra, rb, rs, 16, 15, 1'b0, 1'b1, e3, o3);
            run_vec($sformatf("rnd%0d %h*%h s%0d", i, ra, rb, rs), ra, rb, rs,
                    e0, e1[15:0], e2[15:0], e3[15:0], {o0, o1, o2, o3});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
